// File: rtl/wdt_controller_pkg.sv
// -----------------------------------------------------------------------------
// wdt_controller_pkg
// Shared constants and types for the watchdog timer slave: bus widths and
// access-size encodings, register addresses, the kick magic value, the FSM
// state type and a helper that returns the legal access size per register.
// Optional feature macro used by importers: WDT_WINDOW_EN (adds WINDOW reg).
// -----------------------------------------------------------------------------
package wdt_controller_pkg;

    localparam int WDT_VA_WIDTH  = 5;
    localparam int BUS_ACC_WIDTH = 2;
    localparam int BUS_WIDTH     = 32;

    // Access size encoding shared with the other peripheral slaves.
    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

    localparam logic [WDT_VA_WIDTH-1:0] WDT_ADDR_CTRL   = 5'd0;
    localparam logic [WDT_VA_WIDTH-1:0] WDT_ADDR_RELOAD = 5'd4;
    localparam logic [WDT_VA_WIDTH-1:0] WDT_ADDR_KICK   = 5'd8;
    localparam logic [WDT_VA_WIDTH-1:0] WDT_ADDR_COUNT  = 5'd12;
    localparam logic [WDT_VA_WIDTH-1:0] WDT_ADDR_WINDOW = 5'd16;

    localparam logic [7:0] WDT_KICK_MAGIC = 8'h5A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_BITE = 2'd2
    } wdt_state_e;

    // Byte-wide registers are CTRL and KICK; everything else is a word.
    function automatic logic [BUS_ACC_WIDTH-1:0] wdt_reg_acc(
        input logic [WDT_VA_WIDTH-1:0] a
    );
        logic [BUS_ACC_WIDTH-1:0] sz;
        case (a)
            WDT_ADDR_CTRL,
            WDT_ADDR_KICK: sz = BUS_ACC_1B;
            default:       sz = BUS_ACC_4B;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/wdt_controller_prescaler.sv
// -----------------------------------------------------------------------------
// wdt_controller_prescaler
// Free-running divide-by-PRESCALE tick generator for the watchdog counter.
// The count advances only while en=1 and is forced to 0 by clear (clear wins).
// tick is high for the one cycle in which the count sits at PRESCALE-1 with
// en=1; the count then wraps naturally because PRESCALE is a power of two.
// Ports:
//   clk    in   system clock
//   rstn   in   synchronous active-low reset
//   en     in   advance enable
//   clear  in   restart the prescale period
//   tick   out  one-cycle tick at the end of each period
// -----------------------------------------------------------------------------
module wdt_controller_prescaler #(
    parameter int PRESCALE = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int              PW   = $clog2(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_cnt;

    assign tick = en && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/wdt_controller.sv
// -----------------------------------------------------------------------------
// wdt_controller
// Bus-slave watchdog. Its active-low bite output feeds the reset controller's
// external reset input, so a missed kick resets the SoC. Once bitten, the
// output stays low and the counter freezes until rstn is sampled low.
// Optional feature macro: WDT_WINDOW_EN adds a WINDOW register; a kick while
// COUNT > WINDOW is treated as early and bites instead of reloading.
// Ports:
//   clk        in   system clock
//   rstn       in   synchronous active-low reset
//   wdt_rst_b  out  active-low bite (to reset controller rst_ib)
//   addr       in   register address
//   w_rb       in   1=write, 0=read
//   acc        in   access size
//   rdata      out  read data, registered with resp, 0 when resp=0
//   wdata      in   write data
//   req        in   access request
//   resp       out  access done, registered
//   fault      out  invalid access, combinational
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | EN=0, prescaler and counter frozen
// ST_RUN  | EN=1, prescaler running, counter decrements on each tick
// ST_BITE | timeout or early kick seen, bite held until rstn
// -----------------------------------------------------------------------------
module wdt_controller
    import wdt_controller_pkg::*;
#(
    parameter int CNT_WIDTH = 24,
    parameter int PRESCALE  = 1024
) (
    input  logic                     clk,
    input  logic                     rstn,
    output logic                     wdt_rst_b,
    input  logic [WDT_VA_WIDTH-1:0]  addr,
    input  logic                     w_rb,
    input  logic [BUS_ACC_WIDTH-1:0] acc,
    output logic [BUS_WIDTH-1:0]     rdata,
    input  logic [BUS_WIDTH-1:0]     wdata,
    input  logic                     req,
    output logic                     resp,
    output logic                     fault
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 r_en;
    logic                 r_lock;
    logic [CNT_WIDTH-1:0] r_reload;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_resp;
    logic [BUS_WIDTH-1:0] r_rdata;
    wdt_state_e           r_state;
`ifdef WDT_WINDOW_EN
    logic [CNT_WIDTH-1:0] r_window;
`endif

    wdt_state_e           w_state_nxt;
    logic                 w_invld;
    logic [BUS_WIDTH-1:0] w_rd_data;
    logic                 w_reload_bad;
    logic                 w_acc_ok;
    logic                 w_wr_ok;
    logic                 w_ctrl_wr;
    logic                 w_reload_wr;
    logic                 w_kick;
    logic                 w_early;
    logic                 w_kick_reload;
    logic                 w_en_rise;
    logic                 w_en_nxt;
    logic                 w_presc_en;
    logic                 w_presc_clr;
    logic                 w_tick;
    logic                 w_bite_evt;

    // ---------------------------------------------------------------- decode
    // RELOAD must be non-zero and fit in CNT_WIDTH bits; the shift yields 0
    // when CNT_WIDTH is 32, so every 32-bit value fits in that case.
    assign w_reload_bad = (wdata == '0) || ((wdata >> CNT_WIDTH) != '0);

    always_comb begin
        w_invld   = (acc != wdt_reg_acc(addr));
        w_rd_data = '0;
        case (addr)
            WDT_ADDR_CTRL: begin
                w_rd_data = BUS_WIDTH'({r_lock, r_en});
                if (w_rb && ((wdata[7:2] != 6'd0) || (r_lock && r_en && !wdata[0])))
                    w_invld = 1'b1;
            end
            WDT_ADDR_RELOAD: begin
                w_rd_data = BUS_WIDTH'(r_reload);
                if (w_rb && (r_lock || w_reload_bad))
                    w_invld = 1'b1;
            end
            WDT_ADDR_KICK: begin
                if (!w_rb || (wdata[7:0] != WDT_KICK_MAGIC))
                    w_invld = 1'b1;
            end
            WDT_ADDR_COUNT: begin
                w_rd_data = BUS_WIDTH'(r_count);
                if (w_rb)
                    w_invld = 1'b1;
            end
`ifdef WDT_WINDOW_EN
            WDT_ADDR_WINDOW: begin
                w_rd_data = BUS_WIDTH'(r_window);
                if (w_rb && (r_lock || (wdata > BUS_WIDTH'(r_reload))))
                    w_invld = 1'b1;
            end
`endif
            default: w_invld = 1'b1;
        endcase
    end

    assign fault       = req && w_invld;
    assign w_acc_ok    = req && !w_invld;
    assign w_wr_ok     = w_acc_ok && w_rb;
    assign w_ctrl_wr   = w_wr_ok && (addr == WDT_ADDR_CTRL);
    assign w_reload_wr = w_wr_ok && (addr == WDT_ADDR_RELOAD);
    assign w_kick      = w_wr_ok && (addr == WDT_ADDR_KICK);
    assign w_en_rise   = w_ctrl_wr && !r_en && wdata[0];
    assign w_en_nxt    = w_ctrl_wr ? wdata[0] : r_en;

`ifdef WDT_WINDOW_EN
    assign w_early = (r_count > r_window);
`else
    assign w_early = 1'b0;
`endif

    assign w_kick_reload = w_kick && !w_early;
    assign w_presc_clr   = w_kick_reload || w_en_rise;

    // A kick always wins over a coincident tick; an early kick bites even if
    // the counter would have survived.
    assign w_bite_evt = (r_state != ST_BITE) &&
                        ((w_kick && w_early) ||
                         (w_tick && !w_kick && (r_count == '0)));

    // ------------------------------------------------------------- prescaler
    wdt_controller_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rstn  (rstn),
        .en    (w_presc_en),
        .clear (w_presc_clr),
        .tick  (w_tick)
    );

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BITE: w_state_nxt = ST_BITE;
            default: begin
                if (w_bite_evt)
                    w_state_nxt = ST_BITE;
                else if (w_en_nxt)
                    w_state_nxt = ST_RUN;
                else
                    w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_presc_en = (r_state == ST_RUN);
        wdt_rst_b  = (r_state != ST_BITE);
    end

    // --------------------------------------------------------------- counter
    // Frozen while bitten: neither kicks nor enables may revive it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count <= CNT_MAX;
        end else if (r_state != ST_BITE) begin
            if (w_kick_reload || w_en_rise)
                r_count <= r_reload;
            else if (w_tick && (r_count != '0))
                r_count <= r_count - CNT_WIDTH'(1);
        end
    end

    // ------------------------------------------------------ registers + bus
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_en     <= 1'b0;
            r_lock   <= 1'b0;
            r_reload <= CNT_MAX;
            r_resp   <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_en   <= wdata[0];
                r_lock <= r_lock | wdata[1];
            end
            if (w_reload_wr)
                r_reload <= wdata[CNT_WIDTH-1:0];
            r_resp  <= w_acc_ok;
            r_rdata <= (w_acc_ok && !w_rb) ? w_rd_data : '0;
        end
    end

`ifdef WDT_WINDOW_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_window <= '0;
        end else if (w_wr_ok && (addr == WDT_ADDR_WINDOW)) begin
            r_window <= wdata[CNT_WIDTH-1:0];
        end
    end
`endif

    assign resp  = r_resp;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_wdt_controller.sv
module tb_wdt_controller;
    import wdt_controller_pkg::*;

    localparam int CW = 24;
    localparam int PS = 4;
    localparam logic [1:0] SZ1 = 2'd0;
    localparam logic [1:0] SZ2 = 2'd1;
    localparam logic [1:0] SZ4 = 2'd2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wdt_rst_b;
    logic [4:0]  addr = '0;
    logic        w_rb = 1'b0;
    logic [1:0]  acc = '0;
    logic [31:0] rdata;
    logic [31:0] wdata = '0;
    logic        req = 1'b0;
    logic        resp;
    logic        fault;

    always #5 clk = ~clk;

    wdt_controller #(.CNT_WIDTH(CW), .PRESCALE(PS)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .wdt_rst_b (wdt_rst_b),
        .addr      (addr),
        .w_rb      (w_rb),
        .acc       (acc),
        .rdata     (rdata),
        .wdata     (wdata),
        .req       (req),
        .resp      (resp),
        .fault     (fault)
    );

    typedef struct {
        string       nm;
        logic        flt;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        logic        flt;
        logic        rsp;
        logic [31:0] rd;
    } obs_t;

    exp_t sb_q[$];
    obs_t ob_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // One bus access: expectation queued at drive time, observation queued
    // when the DUT answers (fault mid-cycle, resp/rdata just after the edge).
    task automatic bus_xfer(input string nm, input logic wr, input logic [4:0] a,
                            input logic [1:0] sz, input logic [31:0] wd,
                            input logic e_flt, input logic [31:0] e_rd);
        exp_t e;
        obs_t o;
        e.nm = nm; e.flt = e_flt; e.rd = e_rd;
        sb_q.push_back(e);
        @(negedge clk);
        req = 1'b1; w_rb = wr; addr = a; acc = sz; wdata = wd;
        #1 o.flt = fault;
        @(posedge clk);
        #1 o.rsp = resp; o.rd = rdata;
        req = 1'b0;
        ob_q.push_back(o);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e; obs_t o;
        @(negedge clk);
        rstn = 1'b0; req = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (wdt_rst_b !== 1'b1 || resp !== 1'b0 || rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: wdt_rst_b=%b resp=%b rdata=%h, expected 1/0/00000000",
                     wdt_rst_b, resp, rdata);
        end
        @(negedge clk); rstn = 1'b1;
        bus_xfer("rst_ctrl",   1'b0, WDT_ADDR_CTRL,   SZ1, 32'h0, 1'b0, 32'h0);
        bus_xfer("rst_reload", 1'b0, WDT_ADDR_RELOAD, SZ4, 32'h0, 1'b0, 32'h00FF_FFFF);
        bus_xfer("rst_count",  1'b0, WDT_ADDR_COUNT,  SZ4, 32'h0, 1'b0, 32'h00FF_FFFF);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = ob_q.pop_front(); n_vec++;
            if (o.flt !== e.flt || o.rsp !== !e.flt || o.rd !== e.rd) begin
                n_err++;
                $display("FAIL %s: fault=%b resp=%b rdata=%h, expected fault=%b resp=%b rdata=%h",
                         e.nm, o.flt, o.rsp, o.rd, e.flt, !e.flt, e.rd);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e; obs_t o;
        do_reset();
        bus_xfer("to_reload", 1'b1, WDT_ADDR_RELOAD, SZ4, 32'd3, 1'b0, 32'h0);
        bus_xfer("to_enable", 1'b1, WDT_ADDR_CTRL,   SZ1, 32'h1, 1'b0, 32'h0);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (wdt_rst_b !== ((k >= 16) ? 1'b0 : 1'b1)) begin
                n_err++;
                $display("FAIL timeout_edge%0d: wdt_rst_b=%b, expected %b",
                         k, wdt_rst_b, (k >= 16) ? 1'b0 : 1'b1);
            end
        end
        repeat (5) @(posedge clk);
        #1 n_vec++;
        if (wdt_rst_b !== 1'b0) begin
            n_err++;
            $display("FAIL bite_hold: wdt_rst_b=%b, expected 0", wdt_rst_b);
        end
        bus_xfer("bite_count", 1'b0, WDT_ADDR_COUNT, SZ4, 32'h0, 1'b0, 32'h0);
        bus_xfer("bite_ctrl",  1'b0, WDT_ADDR_CTRL,  SZ1, 32'h0, 1'b0, 32'h1);
        bus_xfer("bite_kick",  1'b1, WDT_ADDR_KICK,  SZ1, 32'h5A, 1'b0, 32'h0);
        @(negedge clk); rstn = 1'b0;
        #1 n_vec++;
        if (wdt_rst_b !== 1'b0) begin
            n_err++;
            $display("FAIL bite_before_rst: wdt_rst_b=%b, expected 0", wdt_rst_b);
        end
        @(posedge clk); #1;
        n_vec++;
        if (wdt_rst_b !== 1'b1) begin
            n_err++;
            $display("FAIL bite_release: wdt_rst_b=%b, expected 1", wdt_rst_b);
        end
        @(negedge clk); rstn = 1'b1;
        bus_xfer("post_rst_count", 1'b0, WDT_ADDR_COUNT, SZ4, 32'h0, 1'b0, 32'h00FF_FFFF);
        bus_xfer("post_rst_ctrl",  1'b0, WDT_ADDR_CTRL,  SZ1, 32'h0, 1'b0, 32'h0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = ob_q.pop_front(); n_vec++;
            if (o.flt !== e.flt || o.rsp !== !e.flt || o.rd !== e.rd) begin
                n_err++;
                $display("FAIL %s: fault=%b resp=%b rdata=%h, expected fault=%b resp=%b rdata=%h",
                         e.nm, o.flt, o.rsp, o.rd, e.flt, !e.flt, e.rd);
            end
        end
    endtask

    task automatic test_kick();
        exp_t e; obs_t o;
        do_reset();
        bus_xfer("k_reload", 1'b1, WDT_ADDR_RELOAD, SZ4, 32'd3, 1'b0, 32'h0);
        bus_xfer("k_enable", 1'b1, WDT_ADDR_CTRL,   SZ1, 32'h1, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            repeat (11) @(posedge clk);
            #1 n_vec++;
            if (wdt_rst_b !== 1'b1) begin
                n_err++;
                $display("FAIL kick_alive%0d: wdt_rst_b=%b, expected 1", i, wdt_rst_b);
            end
            bus_xfer("k_periodic", 1'b1, WDT_ADDR_KICK, SZ1, 32'h5A, 1'b0, 32'h0);
        end
        bus_xfer("k_count_reloaded", 1'b0, WDT_ADDR_COUNT, SZ4, 32'h0, 1'b0, 32'd3);
        repeat (4) @(posedge clk);
        bus_xfer("k_bad_magic", 1'b1, WDT_ADDR_KICK, SZ1, 32'h33, 1'b1, 32'h0);
        bus_xfer("k_count_no_reload", 1'b0, WDT_ADDR_COUNT, SZ4, 32'h0, 1'b0, 32'd2);
        bus_xfer("k_final", 1'b1, WDT_ADDR_KICK, SZ1, 32'h5A, 1'b0, 32'h0);
        #1 n_vec++;
        if (wdt_rst_b !== 1'b1) begin
            n_err++;
            $display("FAIL kick_no_bite: wdt_rst_b=%b, expected 1", wdt_rst_b);
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = ob_q.pop_front(); n_vec++;
            if (o.flt !== e.flt || o.rsp !== !e.flt || o.rd !== e.rd) begin
                n_err++;
                $display("FAIL %s: fault=%b resp=%b rdata=%h, expected fault=%b resp=%b rdata=%h",
                         e.nm, o.flt, o.rsp, o.rd, e.flt, !e.flt, e.rd);
            end
        end
    endtask

    task automatic test_lock();
        exp_t e; obs_t o;
        do_reset();
        bus_xfer("l_reload5",     1'b1, WDT_ADDR_RELOAD, SZ4, 32'd5,  1'b0, 32'h0);
        bus_xfer("l_lock_en",     1'b1, WDT_ADDR_CTRL,   SZ1, 32'h3,  1'b0, 32'h0);
        bus_xfer("l_clear_en",    1'b1, WDT_ADDR_CTRL,   SZ1, 32'h0,  1'b1, 32'h0);
        bus_xfer("l_reload9",     1'b1, WDT_ADDR_RELOAD, SZ4, 32'd9,  1'b1, 32'h0);
        bus_xfer("l_ctrl_rsvd",   1'b1, WDT_ADDR_CTRL,   SZ1, 32'h5,  1'b1, 32'h0);
        bus_xfer("l_lock_sticky", 1'b1, WDT_ADDR_CTRL,   SZ1, 32'h1,  1'b0, 32'h0);
        bus_xfer("l_rd_ctrl",     1'b0, WDT_ADDR_CTRL,   SZ1, 32'h0,  1'b0, 32'h3);
        bus_xfer("l_rd_reload",   1'b0, WDT_ADDR_RELOAD, SZ4, 32'h0,  1'b0, 32'd5);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = ob_q.pop_front(); n_vec++;
            if (o.flt !== e.flt || o.rsp !== !e.flt || o.rd !== e.rd) begin
                n_err++;
                $display("FAIL %s: fault=%b resp=%b rdata=%h, expected fault=%b resp=%b rdata=%h",
                         e.nm, o.flt, o.rsp, o.rd, e.flt, !e.flt, e.rd);
            end
        end
    endtask

    task automatic test_coincident();
        exp_t e; obs_t o;
        do_reset();
        bus_xfer("c_reload", 1'b1, WDT_ADDR_RELOAD, SZ4, 32'd3, 1'b0, 32'h0);
        bus_xfer("c_enable", 1'b1, WDT_ADDR_CTRL,   SZ1, 32'h1, 1'b0, 32'h0);
        repeat (15) @(posedge clk);
        // Lands on the edge where COUNT==0 and the prescaler ticks.
        bus_xfer("c_kick_at_zero", 1'b1, WDT_ADDR_KICK, SZ1, 32'h5A, 1'b0, 32'h0);
        #1 n_vec++;
        if (wdt_rst_b !== 1'b1) begin
            n_err++;
            $display("FAIL coincident_no_bite: wdt_rst_b=%b, expected 1", wdt_rst_b);
        end
        bus_xfer("c_count3",     1'b0, WDT_ADDR_COUNT,  SZ4, 32'h0,  1'b0, 32'd3);
        bus_xfer("c_reload7",    1'b1, WDT_ADDR_RELOAD, SZ4, 32'd7,  1'b0, 32'h0);
        bus_xfer("c_count_kept", 1'b0, WDT_ADDR_COUNT,  SZ4, 32'h0,  1'b0, 32'd3);
        bus_xfer("c_kick_tick",  1'b1, WDT_ADDR_KICK,   SZ1, 32'h5A, 1'b0, 32'h0);
        bus_xfer("c_count7",     1'b0, WDT_ADDR_COUNT,  SZ4, 32'h0,  1'b0, 32'd7);
        #1 n_vec++;
        if (wdt_rst_b !== 1'b1) begin
            n_err++;
            $display("FAIL coincident_alive: wdt_rst_b=%b, expected 1", wdt_rst_b);
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = ob_q.pop_front(); n_vec++;
            if (o.flt !== e.flt || o.rsp !== !e.flt || o.rd !== e.rd) begin
                n_err++;
                $display("FAIL %s: fault=%b resp=%b rdata=%h, expected fault=%b resp=%b rdata=%h",
                         e.nm, o.flt, o.rsp, o.rd, e.flt, !e.flt, e.rd);
            end
        end
    endtask

    task automatic test_faults();
        exp_t e; obs_t o;
        do_reset();
        bus_xfer("f_ctrl_2b",     1'b0, WDT_ADDR_CTRL,   SZ2, 32'h0,         1'b1, 32'h0);
        bus_xfer("f_addr20",      1'b0, 5'd20,           SZ4, 32'h0,         1'b1, 32'h0);
        bus_xfer("f_addr2",       1'b0, 5'd2,            SZ1, 32'h0,         1'b1, 32'h0);
        bus_xfer("f_rd_kick",     1'b0, WDT_ADDR_KICK,   SZ1, 32'h0,         1'b1, 32'h0);
        bus_xfer("f_wr_count",    1'b1, WDT_ADDR_COUNT,  SZ4, 32'h5,         1'b1, 32'h0);
        bus_xfer("f_reload0",     1'b1, WDT_ADDR_RELOAD, SZ4, 32'h0,         1'b1, 32'h0);
        bus_xfer("f_reload_big",  1'b1, WDT_ADDR_RELOAD, SZ4, 32'h0100_0000, 1'b1, 32'h0);
        bus_xfer("f_kick_4b",     1'b1, WDT_ADDR_KICK,   SZ4, 32'h5A,        1'b1, 32'h0);
        bus_xfer("f_rd_reload",   1'b0, WDT_ADDR_RELOAD, SZ4, 32'h0,         1'b0, 32'h00FF_FFFF);
        bus_xfer("f_reload_max",  1'b1, WDT_ADDR_RELOAD, SZ4, 32'h00FF_FFFE, 1'b0, 32'h0);
        bus_xfer("f_rd_reload2",  1'b0, WDT_ADDR_RELOAD, SZ4, 32'h0,         1'b0, 32'h00FF_FFFE);
`ifdef WDT_WINDOW_EN
        bus_xfer("f_rd_window",   1'b0, WDT_ADDR_WINDOW, SZ4, 32'h0,         1'b0, 32'h0);
`else
        bus_xfer("f_rd_window",   1'b0, WDT_ADDR_WINDOW, SZ4, 32'h0,         1'b1, 32'h0);
`endif
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = ob_q.pop_front(); n_vec++;
            if (o.flt !== e.flt || o.rsp !== !e.flt || o.rd !== e.rd) begin
                n_err++;
                $display("FAIL %s: fault=%b resp=%b rdata=%h, expected fault=%b resp=%b rdata=%h",
                         e.nm, o.flt, o.rsp, o.rd, e.flt, !e.flt, e.rd);
            end
        end
    endtask

`ifdef WDT_WINDOW_EN
    task automatic test_window();
        exp_t e; obs_t o;
        do_reset();
        bus_xfer("w_reload10", 1'b1, WDT_ADDR_RELOAD, SZ4, 32'd10, 1'b0, 32'h0);
        bus_xfer("w_win11",    1'b1, WDT_ADDR_WINDOW, SZ4, 32'd11, 1'b1, 32'h0);
        bus_xfer("w_win4",     1'b1, WDT_ADDR_WINDOW, SZ4, 32'd4,  1'b0, 32'h0);
        bus_xfer("w_enable",   1'b1, WDT_ADDR_CTRL,   SZ1, 32'h1,  1'b0, 32'h0);
        repeat (13) @(posedge clk);
        bus_xfer("w_early_kick", 1'b1, WDT_ADDR_KICK, SZ1, 32'h5A, 1'b0, 32'h0);
        #1 n_vec++;
        if (wdt_rst_b !== 1'b0) begin
            n_err++;
            $display("FAIL window_early_bite: wdt_rst_b=%b, expected 0", wdt_rst_b);
        end
        bus_xfer("w_count_frozen", 1'b0, WDT_ADDR_COUNT, SZ4, 32'h0, 1'b0, 32'd7);
        do_reset();
        bus_xfer("w2_reload10", 1'b1, WDT_ADDR_RELOAD, SZ4, 32'd10, 1'b0, 32'h0);
        bus_xfer("w2_win4",     1'b1, WDT_ADDR_WINDOW, SZ4, 32'd4,  1'b0, 32'h0);
        bus_xfer("w2_enable",   1'b1, WDT_ADDR_CTRL,   SZ1, 32'h1,  1'b0, 32'h0);
        repeat (28) @(posedge clk);
        bus_xfer("w2_ok_kick",  1'b1, WDT_ADDR_KICK,   SZ1, 32'h5A, 1'b0, 32'h0);
        #1 n_vec++;
        if (wdt_rst_b !== 1'b1) begin
            n_err++;
            $display("FAIL window_ok_kick: wdt_rst_b=%b, expected 1", wdt_rst_b);
        end
        bus_xfer("w2_count10", 1'b0, WDT_ADDR_COUNT, SZ4, 32'h0, 1'b0, 32'd10);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = ob_q.pop_front(); n_vec++;
            if (o.flt !== e.flt || o.rsp !== !e.flt || o.rd !== e.rd) begin
                n_err++;
                $display("FAIL %s: fault=%b resp=%b rdata=%h, expected fault=%b resp=%b rdata=%h",
                         e.nm, o.flt, o.rsp, o.rd, e.flt, !e.flt, e.rd);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_timeout();
        test_kick();
        test_lock();
        test_coincident();
        test_faults();
`ifdef WDT_WINDOW_EN
        test_window();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wdt_controller.md
Name: wdt_controller

Overview:
- Bus-slave watchdog timer that sits directly upstream of the reset controller.
- Its active-low bite output drives the reset controller's external reset input (rst_ib), so a missed kick resets the whole SoC.
- Its own rstn comes from one bit of the reset controller's rst_ob vector.
- Bus interface uses the same req/resp/fault protocol as the other peripheral slaves.

Parameters:
- CNT_WIDTH, 24, width of timeout down-counter; 1..32.
- PRESCALE, 1024, clk cycles per counter tick; power of two, >=2.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- wdt_rst_b  out  1  active-low bite; drives reset controller rst_ib
- addr  in  `WDT_VA_WIDTH  register address
- w_rb  in  1  1=write, 0=read
- acc  in  `BUS_ACC_WIDTH  access size
- rdata  out  `BUS_WIDTH  read data, valid with resp
- wdata  in  `BUS_WIDTH  write data
- req  in  1  access request
- resp  out  1  access done, registered
- fault  out  1  invalid access, combinational

Behaviour:
- Register map (address, size, access):
  - CTRL, 0, 1B, RW: bit0 EN, bit1 LOCK (write-1 sticky, cleared only by rstn); bits[7:2] read 0.
  - RELOAD, 4, 4B, RW: timeout value.
  - KICK, 8, 1B, W: only 0x5A is accepted.
  - COUNT, 12, 4B, R: current counter, zero-extended.
- fault = req & invld (combinational). invld covers:
  - unmapped address, or access size not equal to the register size;
  - write to COUNT, or read of KICK;
  - CTRL write with wdata[7:2]!=0, or CTRL write clearing EN while LOCK=1;
  - RELOAD write while LOCK=1, or RELOAD write of 0 or >=2^CNT_WIDTH;
  - KICK write with wdata[7:0]!=0x5A.
- Faulting accesses have no side effect and never produce resp.
- resp is registered: resp <= req & ~invld, so it rises 1 cycle after a valid req. rdata is registered with resp and is 0 when resp=0.
- Reset values (rstn=0 sampled at clk):
  - CTRL=0, RELOAD=2^CNT_WIDTH-1, COUNT=RELOAD, prescaler=0;
  - wdt_rst_b=1, resp=0, rdata=0.
- Prescaler (log2(PRESCALE) bits) advances only when EN=1 and no bite is pending. A tick occurs when prescaler==PRESCALE-1; the prescaler wraps to 0.
- On a tick:
  - COUNT!=0: COUNT decrements.
  - COUNT==0: bite. wdt_rst_b goes 0 on the next edge.
  - Timeout from last kick = (RELOAD+1)*PRESCALE cycles.
- Valid KICK write: COUNT<=RELOAD, prescaler<=0.
- CTRL write changing EN 0->1 also reloads COUNT and the prescaler.
- EN=0: prescaler and COUNT frozen.
- Simultaneous events: kick in the same cycle as a tick means the kick wins and no decrement or bite occurs. A RELOAD write takes effect at the next kick or enable and does not change COUNT.
- Bite is sticky:
  - wdt_rst_b stays 0, and the counter and prescaler freeze, until rstn=0 is sampled.
  - Accesses still respond normally while the bite is held.
  - This guarantees at least 2 cycles low, since the reset controller registers rst_ib and then drives rstn low.
- rstn mid-operation: everything returns to reset values on the next edge, with no bite.

Optional Feature:
- Macro WDT_WINDOW_EN adds a WINDOW register at address 16 (4B, RW, reset 0, locked by LOCK, must be <=RELOAD else fault).
- With the macro: a valid KICK while COUNT>WINDOW is an early kick. It causes an immediate bite (wdt_rst_b=0 next edge) instead of a reload, and resp is still returned.
- Without the macro: address 16 faults and kicks are always accepted.

Decomposition:
- femto.vh: `WDT_VA_WIDTH (5), register address constants, the kick magic 0x5A.
- Existing `BUS_ACC_*/`BUS_WIDTH are reused.
- One natural sub-module, wdt_prescaler: tick generator with en, clear, and tick output.
- The decode/fault logic and counter stay in wdt_controller.

Test Plan:
- Reset then read CTRL/RELOAD/COUNT -> 0x0 / 0xFFFFFF / 0xFFFFFF; wdt_rst_b=1; resp 1 cycle after req.
- RELOAD=3, EN=1, no kicks, PRESCALE=4 -> wdt_rst_b falls exactly 16 cycles after the enable write's edge and holds until rstn=0, then returns to 1.
- RELOAD=3, EN=1, kick with 0x5A every 12 cycles for 100 cycles -> no bite. Kick with 0x33 -> fault=1, no resp, no reload.
- LOCK=1, then write CTRL=0 and RELOAD=9 -> both fault, values unchanged. Read CTRL -> 0x3.
- Kick coincident with tick at COUNT==0 -> COUNT=RELOAD, no bite. Bad size (2B to CTRL) or addr 20 -> fault.
- WDT_WINDOW_EN: RELOAD=10, WINDOW=4, kick at COUNT=7 -> bite next edge. Kick at COUNT=3 -> reload to 10.
